// File: rtl/hex_decoder_if.sv
//------------------------------------------------------------------------------
// hex_decoder_if
// Digit-in / word-out handshake bundle for hex_decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hex_decoder_if #(
    parameter int NUM_HEX = 6
) ();
    logic [6:0]           seg_in;
    logic                 seg_valid;
    logic                 seg_ready;
    logic                 flush;
    logic [NUM_HEX*4-1:0] num;
    logic                 num_valid;
    logic                 num_ready;
    logic                 err;
    logic [2:0]           err_pos;

    modport master (
        output seg_in, seg_valid, flush, num_ready,
        input  seg_ready, num, num_valid, err, err_pos
    );

    modport slave (
        input  seg_in, seg_valid, flush, num_ready,
        output seg_ready, num, num_valid, err, err_pos
    );
endinterface

`default_nettype wire

// File: rtl/hex_decoder.sv
//------------------------------------------------------------------------------
// hex_decoder
// Decodes active-low 7-segment digits and assembles NUM_HEX of them, MSB first,
// into one word handed off through a valid/ready hold stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_decoder #(
    parameter int NUM_HEX = 6
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hex_decoder_if.slave bus
);
    localparam int c_width = NUM_HEX * 4;
    localparam int c_cw    = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(NUM_HEX - 1);
    localparam logic [2:0]      c_pos_top  = 3'(NUM_HEX - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cw-1:0]    r_cnt;
    logic [c_cw-1:0]    w_cnt_nxt;
    logic [c_width-1:0] r_shift;
    logic [c_width-1:0] w_shift_nxt;
    logic [c_width-1:0] w_shifted;
    logic               r_err;
    logic               w_err_nxt;
    logic [2:0]         r_err_pos;
    logic [2:0]         w_err_pos_nxt;
    logic [3:0]         w_nibble;
    logic               w_legal;
    logic               w_seg_ready;

    always_comb begin
        w_nibble = 4'h0;
        w_legal  = 1'b1;
        case (bus.seg_in)
            7'b1000000: w_nibble = 4'h0;
            7'b1111001: w_nibble = 4'h1;
            7'b0100100: w_nibble = 4'h2;
            7'b0110000: w_nibble = 4'h3;
            7'b0011001: w_nibble = 4'h4;
            7'b0010010: w_nibble = 4'h5;
            7'b0000010: w_nibble = 4'h6;
            7'b1111000: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0010000: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b0000011: w_nibble = 4'hB;
            7'b1000110: w_nibble = 4'hC;
            7'b0100001: w_nibble = 4'hD;
            7'b0000110: w_nibble = 4'hE;
            7'b0001110: w_nibble = 4'hF;
            default:    w_legal  = 1'b0;
        endcase
    end

    // A single-digit word has no older nibbles to keep
    generate
        if (NUM_HEX == 1) begin : g_shift_single
            assign w_shifted = w_nibble;
        end else begin : g_shift_multi
            assign w_shifted = {r_shift[c_width-5:0], w_nibble};
        end
    endgenerate

    assign w_seg_ready = rst_n && (r_state == COLLECT);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_err_nxt     = r_err;
        w_err_pos_nxt = r_err_pos;
        if (bus.flush) begin
            w_state_nxt   = COLLECT;
            w_cnt_nxt     = '0;
            w_shift_nxt   = '0;
            w_err_nxt     = 1'b0;
            w_err_pos_nxt = 3'd0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.seg_valid && w_seg_ready) begin
                        w_shift_nxt = w_shifted;
                        // Only the first bad digit of a word is reported
                        if (!w_legal && !r_err) begin
                            w_err_nxt     = 1'b1;
                            w_err_pos_nxt = c_pos_top - 3'(r_cnt);
                        end
                        if (r_cnt == c_cnt_last) begin
                            w_state_nxt = HOLD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cw'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.num_ready) begin
                        w_state_nxt   = COLLECT;
                        w_err_nxt     = 1'b0;
                        w_err_pos_nxt = 3'd0;
                    end
                end
                default: w_state_nxt = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_err     <= 1'b0;
            r_err_pos <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_err     <= w_err_nxt;
            r_err_pos <= w_err_pos_nxt;
        end
    end

    assign bus.seg_ready = w_seg_ready;
    assign bus.num       = r_shift;
    assign bus.num_valid = (r_state == HOLD);
    assign bus.err       = r_err;
    assign bus.err_pos   = r_err_pos;
endmodule

`default_nettype wire
